mac_unit_basic: RTL and testbench

MAC_UNIT_BASIC -- requirements
Module: mac_unit_basic

---
 rtl/mac_unit_basic.sv | 91 +++++++++
 tb/tb_mac_unit_basic.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mac_unit_basic.sv
// mac_unit_basic: signed multiply-accumulate with registered output.
// Optional clamp of every accumulator update: define MAC_UNIT_SATURATE_EN.
module mac_unit_basic #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear_accum,
  input  logic signed [DATA_WIDTH-1:0]  data_in,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_in,
  output logic signed [ACCUM_WIDTH-1:0] accum_out,
  output logic                          valid_out
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int AW = ACCUM_WIDTH;

  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_next;
  logic signed [AW-1:0] r_accum;
  logic                 r_valid;

  assign w_prod = data_in * weight_in;

`ifdef MAC_UNIT_SATURATE_EN
  // One guard bit above the wider of product/accumulator holds any sum.
  localparam int MW = (PW > AW) ? PW : AW;
  localparam int SW = MW + 1;
  localparam logic signed [SW-1:0] SMAX =
    {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  logic signed [SW-1:0] w_prod_s;
  logic signed [SW-1:0] w_acc_s;
  logic signed [SW-1:0] w_sum_s;

  assign w_prod_s = {{(SW-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_s  = {{(SW-AW){r_accum[AW-1]}}, r_accum};

  // Exact sum (or clear load), then clamp to the accumulator range.
  always_comb begin
    w_sum_s = clear_accum ? w_prod_s : (w_acc_s + w_prod_s);
    w_next  = w_sum_s[AW-1:0];
    if (w_sum_s > SMAX) begin
      w_next = SMAX[AW-1:0];
    end else if (w_sum_s < SMIN) begin
      w_next = SMIN[AW-1:0];
    end
  end
`else
  logic signed [AW-1:0] w_prod_a;

  // Fit the product to the accumulator: sign-extend or wrap to low bits.
  if (PW >= AW) begin : g_trunc
    assign w_prod_a = w_prod[AW-1:0];
  end else begin : g_sext
    assign w_prod_a = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  end

  // Modular add (or clear load); overflow wraps naturally.
  always_comb begin
    w_next = clear_accum ? w_prod_a : (r_accum + w_prod_a);
  end
`endif

  // Accumulator updates only on enabled edges; reset discards partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accum <= '0;
    end else if (enable) begin
      r_accum <= w_next;
    end
  end

  // valid_out marks the cycle right after each enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= enable;
    end
  end

  assign accum_out = r_accum;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_mac_unit_basic.sv
// tb_mac_unit_basic: directed + random stimulus, queue scoreboard.
// Honours MAC_UNIT_SATURATE_EN in its reference model.
module tb_mac_unit_basic;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               clear_accum;
  logic signed [15:0] data_in;
  logic signed [7:0]  weight_in;
  logic signed [23:0] accum_out;
  logic               valid_out;

  typedef struct {
    logic [23:0] acc;
    logic        v;
    string       tag;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp;
  int     n_bad;
  longint m_acc;
  logic   m_v;

  mac_unit_basic dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear_accum (clear_accum),
    .data_in     (data_in),
    .weight_in   (weight_in),
    .accum_out   (accum_out),
    .valid_out   (valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [23:0] obs_a,
                     input logic obs_v, input logic [23:0] exp_a,
                     input logic exp_v);
    n_cmp++;
    assert (obs_a === exp_a) else begin
      n_bad++;
      $error("FAIL %s accum: got %h want %h", tag, obs_a, exp_a);
    end
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_bad++;
      $error("FAIL %s valid: got %b want %b", tag, obs_v, exp_v);
    end
  endtask

  // Reference model: exact arithmetic, then clamp or wrap to 24 bits.
  task automatic model(input logic en, input logic clr,
                       input int d, input int w);
    longint p;
    longint s;
    logic [23:0] t;
    if (en) begin
      p = longint'(d) * longint'(w);
      s = clr ? p : (m_acc + p);
`ifdef MAC_UNIT_SATURATE_EN
      if (s > 64'sd8388607) s = 64'sd8388607;
      if (s < -64'sd8388608) s = -64'sd8388608;
      m_acc = s;
`else
      t = s[23:0];
      m_acc = longint'($signed(t));
`endif
    end
    m_v = en;
  endtask

  // Drive one cycle, push expectation, compare after the edge.
  task automatic step(input string tag, input logic en, input logic clr,
                      input int d, input int w);
    exp_t e;
    exp_t g;
    logic [23:0] ea;
    enable      = en;
    clear_accum = clr;
    data_in     = 16'(d);
    weight_in   = 8'(w);
    model(en, clr, d, w);
    ea    = m_acc[23:0];
    e.acc = ea;
    e.v   = m_v;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s scoreboard: got empty want entry", tag);
    end else begin
      g = sb_q.pop_front();
      chk(g.tag, accum_out, valid_out, g.acc, g.v);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    m_acc       = 0;
    m_v         = 1'b0;
    rst         = 1'b0;
    enable      = 1'b0;
    clear_accum = 1'b0;
    data_in     = '0;
    weight_in   = '0;

    #2 rst = 1'b1;
    #1 chk("rst_async", accum_out, valid_out, 24'h000000, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("rst_held", accum_out, valid_out, 24'h000000, 1'b0);
    rst = 1'b0;
    step("idle0", 1'b0, 1'b0, 0, 0);
    step("idle1", 1'b0, 1'b1, 7, 7);

    step("clr_2x3", 1'b1, 1'b1, 2, 3);
    step("acc_m4x5", 1'b1, 1'b0, -4, 5);
    step("acc_10x1", 1'b1, 1'b0, 10, 1);

    step("clr_5x2", 1'b1, 1'b1, 5, 2);
    step("hold", 1'b0, 1'b1, 99, 9);
    step("acc_1x1", 1'b1, 1'b0, 1, 1);

    step("zero", 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("pos_ovf", 1'b1, 1'b0, 32767, 127);

    step("neg_clr", 1'b1, 1'b1, -32768, -128);
    for (int i = 0; i < 6; i++)
      step("neg_ovf", 1'b1, 1'b0, -32768, 127);

    for (int i = 0; i < 12; i++)
      step("rand", 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0),
           int'($signed(16'($urandom))), int'($signed(8'($urandom))));

    step("pre_rst", 1'b1, 1'b1, 3, 3);
    #3 rst = 1'b1;
    #1 chk("rst_mid", accum_out, valid_out, 24'h000000, 1'b0);
    m_acc = 0;
    m_v   = 1'b0;
    @(posedge clk);
    #1 chk("rst_edge", accum_out, valid_out, 24'h000000, 1'b0);
    rst = 1'b0;
    step("post_idle", 1'b0, 1'b0, 0, 0);
    step("post_1x1", 1'b1, 1'b0, 1, 1);

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_drain: got %0d want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
